// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF) and data (D).
// Latency: request sampled at edge N -> mem_req in cycle N+1; done in the first cycle mem_ready is seen.
// Backpressure: requesters hold req until their done pulse; a watchdog aborts accesses the memory never completes.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_done,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          err,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
   localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WD_MAX  = '1;

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] wd_cnt_q, wd_cnt_d;
   logic          wd_expire;

   // Abort condition: this BUSY cycle is the last one the watchdog allows.
   assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

   // Fetch must stall the pipeline until its completion pulse.
   assign stall = if_req & ~if_done;

   // State, fairness pointer and watchdog registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_IF;
         wd_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wd_cnt_q     <= wd_cnt_d;
      end
   end

   // Arbitration, memory handshake muxing and completion/abort generation.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wd_cnt_d     = wd_cnt_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if_done      = 1'b0;
      if_rdata     = '0;
      d_done       = 1'b0;
      d_rdata      = '0;
      err          = 1'b0;

      case (state_q)
         IDLE: begin
            wd_cnt_d = '0;
            if (if_req && d_req) begin
               // Tie: hand the memory to whoever did not get it last time.
               if (last_grant_q == GNT_IF) begin
                  state_d      = BUSY_D;
                  last_grant_d = GNT_D;
               end else begin
                  state_d      = BUSY_IF;
                  last_grant_d = GNT_IF;
               end
            end else if (if_req) begin
               state_d      = BUSY_IF;
               last_grant_d = GNT_IF;
            end else if (d_req) begin
               state_d      = BUSY_D;
               last_grant_d = GNT_D;
            end
         end

         BUSY_IF: begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            if (mem_ready) begin
               if_done  = 1'b1;
               if_rdata = mem_rdata;
               state_d  = IDLE;
            end else if (wd_expire) begin
               if_done = 1'b1;
               err     = 1'b1;
               state_d = IDLE;
            end else if (wd_cnt_q != WD_MAX) begin
               wd_cnt_d = wd_cnt_q + CW'(1);
            end
         end

         BUSY_D: begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (mem_ready) begin
               d_done  = 1'b1;
               d_rdata = mem_rdata;
               state_d = IDLE;
            end else if (wd_expire) begin
               d_done  = 1'b1;
               err     = 1'b1;
               state_d = IDLE;
            end else if (wd_cnt_q != WD_MAX) begin
               wd_cnt_d = wd_cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, randomized traffic vs reference model.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: bench requesters hold req until done and drop it for one cycle afterwards.
module tb_mem_arbiter;

   localparam int TO = 16;

   logic        clk;
   logic        reset;
   logic        if_req, d_req, d_we, mem_ready;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

   logic        if_done, d_done, err, stall, mem_req, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   logic        if_done0, d_done0, err0, stall0, mem_req0, mem_we0;
   logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .err(err), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done0), .if_rdata(if_rdata0),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done0), .d_rdata(d_rdata0), .err(err0), .stall(stall0),
      .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ifr;
      logic [31:0] ia;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic        rdy;
      logic [31:0] rd;
      logic [133:0] exp;
   } vec_t;

   vec_t tv[14];

   // Reference model: who owns the memory, who was served last, cycles spent so far.
   int m_owner;   // 0 none, 1 fetch, 2 data
   int m_last;    // 1 fetch, 2 data
   int m_elapsed;
   bit m_fin;

   function automatic logic [133:0] obs();
      return {mem_req, mem_we, if_done, d_done, err, stall, mem_addr, mem_wdata, if_rdata, d_rdata};
   endfunction

   function automatic logic [133:0] mk_exp(logic mr, logic mw, logic ifd, logic dd, logic er, logic st,
                                          logic [31:0] ma, logic [31:0] mwd, logic [31:0] ird, logic [31:0] drd);
      return {mr, mw, ifd, dd, er, st, ma, mwd, ird, drd};
   endfunction

   function automatic vec_t mkv(logic ifr, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da,
                                logic [31:0] dwd, logic rdy, logic [31:0] rd, logic [133:0] e);
      vec_t v;
      v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
      v.dwd = dwd; v.rdy = rdy; v.rd = rd; v.exp = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] expv);
      total_cnt++;
      if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
      else pass_cnt++;
   endtask

   task automatic apply(input vec_t v);
      if_req = v.ifr; if_addr = v.ia; d_req = v.dr; d_we = v.dwe; d_addr = v.da;
      d_wdata = v.dwd; mem_ready = v.rdy; mem_rdata = v.rd;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_ready = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      m_owner = 0; m_last = 1; m_elapsed = 0;
   endtask

   // Expected outputs this cycle, from ownership and elapsed time.
   task automatic model_eval(output logic [133:0] e);
      logic [31:0] rdv;
      m_fin = 0;
      if (m_owner == 0) begin
         e = mk_exp(0, 0, 0, 0, 0, if_req, 0, 0, 0, 0);
      end else begin
         m_fin = mem_ready || (TO != 0 && m_elapsed >= TO);
         rdv = mem_ready ? mem_rdata : 32'h0;
         if (m_owner == 1)
            e = mk_exp(1, 0, m_fin, 0, m_fin && !mem_ready, if_req && !m_fin, if_addr, 0,
                       m_fin ? rdv : 32'h0, 0);
         else
            e = mk_exp(1, d_we, 0, m_fin, m_fin && !mem_ready, if_req, d_addr, d_wdata,
                       0, m_fin ? rdv : 32'h0);
      end
   endtask

   task automatic model_step();
      if (m_owner == 0) begin
         if (if_req && d_req) m_owner = (m_last == 2) ? 1 : 2;
         else if (if_req)     m_owner = 1;
         else if (d_req)      m_owner = 2;
         if (m_owner != 0) begin
            m_last    = m_owner;
            m_elapsed = 1;
         end
      end else if (m_fin) begin
         m_owner = 0;
      end else begin
         m_elapsed++;
      end
   endtask

   initial begin
      logic [133:0] e;
      bit if_cool, d_cool;

      tv[0]  = mkv(0, 0,     0, 0, 0,     0,     1, 32'h1111, mk_exp(0,0,0,0,0,0, 0,0,0,0));
      tv[1]  = mkv(1, 'h20,  1, 1, 'h30,  'h1234,0, 32'h2222, mk_exp(0,0,0,0,0,1, 0,0,0,0));
      tv[2]  = mkv(1, 'h20,  1, 1, 'h30,  'h1234,1, 32'h5555, mk_exp(1,1,0,1,0,1, 'h30,'h1234,0,'h5555));
      tv[3]  = mkv(1, 'h20,  0, 0, 0,     0,     0, 32'h3333, mk_exp(0,0,0,0,0,1, 0,0,0,0));
      tv[4]  = mkv(1, 'h20,  0, 0, 0,     0,     1, 32'h7777, mk_exp(1,0,1,0,0,0, 'h20,0,'h7777,0));
      tv[5]  = mkv(0, 0,     0, 0, 0,     0,     1, 32'h4444, mk_exp(0,0,0,0,0,0, 0,0,0,0));
      tv[6]  = mkv(1, 'h24,  1, 0, 'h34,  'h99,  0, 32'h0,    mk_exp(0,0,0,0,0,1, 0,0,0,0));
      tv[7]  = mkv(1, 'h24,  1, 0, 'h34,  'h99,  1, 32'h8888, mk_exp(1,0,0,1,0,1, 'h34,'h99,0,'h8888));
      tv[8]  = mkv(1, 'h24,  0, 0, 0,     0,     0, 32'h0,    mk_exp(0,0,0,0,0,1, 0,0,0,0));
      tv[9]  = mkv(1, 'h24,  0, 0, 0,     0,     1, 32'h10,   mk_exp(1,0,1,0,0,0, 'h24,0,'h10,0));
      tv[10] = mkv(0, 0,     0, 0, 0,     0,     1, 32'h5,    mk_exp(0,0,0,0,0,0, 0,0,0,0));
      tv[11] = mkv(1, 'h10,  0, 0, 0,     0,     1, 32'hCAFE, mk_exp(0,0,0,0,0,1, 0,0,0,0));
      tv[12] = mkv(1, 'h10,  0, 0, 0,     0,     1, 32'hCAFE, mk_exp(1,0,1,0,0,0, 'h10,0,'hCAFE,0));
      tv[13] = mkv(0, 0,     0, 0, 0,     0,     0, 32'h0,    mk_exp(0,0,0,0,0,0, 0,0,0,0));

      reset = 1'b0;
      idle_inputs();
      m_owner = 0; m_last = 1; m_elapsed = 0;

      // Reset state
      @(negedge clk);
      check("reset_outputs", obs(), mk_exp(0,0,0,0,0,0, 0,0,0,0));
      reset = 1'b1;
      @(posedge clk); #1;

      // Arbitration and single-cycle completion vectors
      for (int i = 0; i < 14; i++) begin
         apply(tv[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i), obs(), tv[i].exp);
         @(posedge clk); #1;
      end

      // Store with three wait states
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_ready = 0; mem_rdata = 32'h0;
      @(negedge clk);
      check("st_idle", {133'b0, mem_req}, 134'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         @(negedge clk);
         check($sformatf("st_bus%0d", k), {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h40, 32'hDEADBEEF});
         check($sformatf("st_done%0d", k), {d_done, err, if_done}, {(k == 3), 1'b0, 1'b0});
         @(posedge clk); #1;
      end
      idle_inputs();
      @(negedge clk);
      check("st_after", {mem_req, d_done}, 2'b00);
      @(posedge clk); #1;

      // Watchdog abort, then memory answering on the very last allowed cycle
      for (int pass = 0; pass < 2; pass++) begin
         d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 0; mem_rdata = 32'hFFFF0000;
         @(posedge clk); #1;
         for (int k = 1; k <= TO; k++) begin
            mem_ready = (pass == 1 && k == TO);
            @(negedge clk);
            if (k < TO)
               check($sformatf("wd%0d_wait%0d", pass, k), {mem_req, d_done, err}, 3'b100);
            else if (pass == 0)
               check("wd_abort", {mem_req, d_done, err, d_rdata}, {3'b111, 32'h0});
            else
               check("wd_ready_wins", {mem_req, d_done, err, d_rdata}, {3'b110, 32'hFFFF0000});
            @(posedge clk); #1;
         end
         idle_inputs();
         @(negedge clk);
         check($sformatf("wd%0d_idle", pass), {mem_req, d_done, err}, 3'b000);
         @(posedge clk); #1;
      end

      // Reset in the middle of a fetch
      if_req = 1; if_addr = 32'h50; mem_ready = 0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy", {mem_req, if_done}, 2'b10);
      #1 reset = 1'b0;
      #1 check("rst_drop", {mem_req, mem_we, if_done, err}, 4'b0000);
      @(posedge clk); #1;
      check("rst_hold", {mem_req, if_done}, 2'b00);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1; mem_rdata = 32'hABCD;
      @(negedge clk);
      check("rst_regrant", {mem_req, if_done, err, mem_addr, if_rdata}, {3'b110, 32'h50, 32'hABCD});
      @(posedge clk); #1;
      idle_inputs();

      // Watchdog disabled: long wait completes normally
      do_reset();
      d_req = 1; d_we = 0; d_addr = 32'h90; mem_ready = 0; mem_rdata = 32'h0;
      @(posedge clk); #1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         check($sformatf("nowd_wait%0d", k), {mem_req0, d_done0, err0}, 3'b100);
         @(posedge clk); #1;
      end
      mem_ready = 1; mem_rdata = 32'h600D;
      @(negedge clk);
      check("nowd_done", {d_done0, err0, d_rdata0}, {2'b10, 32'h600D});
      @(posedge clk); #1;
      idle_inputs();

      // Randomized traffic against the reference model
      do_reset();
      if_cool = 0; d_cool = 0;
      for (int i = 0; i < 3000; i++) begin
         if (if_cool) begin
            if_req = 0; if_cool = 0;
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (d_cool) begin
            d_req = 0; d_cool = 0;
         end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
         end
         if ((i % 400) < 300) mem_ready = ($urandom_range(0, 3) != 0);
         else                 mem_ready = ($urandom_range(0, 24) == 0);
         mem_rdata = $urandom;
         @(negedge clk);
         model_eval(e);
         check($sformatf("rand%0d", i), obs(), e);
         if (m_fin && m_owner == 1) if_cool = 1;
         if (m_fin && m_owner == 2) d_cool = 1;
         @(posedge clk);
         model_step();
         #1;
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
